mm_arbiter: RTL and testbench
=============================

# mm_arbiter

Single-port main-memory arbiter and sequencer that sits between the processor's two memory clients and main memory: the instruction-fetch port (read-only) and the data-cache miss/write-back port (read refill or write-back). It grants one requester at a time using round-robin, then drives the main-memory read/write strobes for a fixed number of cycles. It also captures the read data and returns a one-cycle acknowledge to the granted requester. The data cache raises its main-memory read and write requests through this block instead of driving memory directly.

## Interface
- Clocking: one clock, `clk`. Reset `reset` is synchronous and active-high.
- `DATA_W`, 8, data width.
- `ADDR_W`, 8, address width.
- `MEM_LAT`, 2, main-memory access cycles; legal values are 1 or greater.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  instruction-fetch read request, level.
- `i_addr`  in  ADDR_W  fetch address.
- `i_ack`  out  1  one-cycle completion pulse to fetch.
- `i_rdata`  out  DATA_W  read data; valid when `i_ack` is high.
- `d_req`  in  1  data-cache request, level.
- `d_we`  in  1  1 = write-back, 0 = refill read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write-back data.
- `d_ack`  out  1  one-cycle completion pulse to the data cache.
- `d_rdata`  out  DATA_W  refill data; valid when `d_ack` is high on a read.
- `mm_read`  out  1  main-memory read strobe.
- `mm_write`  out  1  main-memory write strobe.
- `mm_addr`  out  ADDR_W  main-memory address.
- `mm_wdata`  out  DATA_W  main-memory write data.
- `mm_rdata`  in  DATA_W  main-memory read data; sampled on the last strobe cycle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Three-state FSM:
  - IDLE: sample the requests.
    - No request: remain in IDLE.
    - Any request: arbitrate and register the winner's addr, wdata and we, plus `owner` (I or D). Go to BUSY.
  - BUSY: drive `mm_read` or `mm_write` (from the registered `we`), `mm_addr` and `mm_wdata` from the registers. A cycle counter runs 0..MEM_LAT-1.
    - When the counter reaches MEM_LAT-1: on a read, capture `mm_rdata` into the response register. Go to ACK.
  - ACK: pulse the owner's ack for one cycle, then return to IDLE.
- Round-robin arbitration:
  - If both requests are high in IDLE, grant the requester not granted last time.
  - If only one request is high, it wins regardless of the pointer.
  - After reset the pointer favours D.
- `i_rdata` and `d_rdata` are both driven from the single response register. The register holds its value until the next read capture; writes leave it unchanged.
- The fetch port never writes. `mm_write` is asserted only when owner = D and `we` = 1.
- Handshake rules:
  - A requester holds req, addr, we and wdata until it sees its ack.
  - It drops req in the cycle after ack, unless it is issuing a new request.
  - Inputs that change after the grant are ignored, because the request was registered.
  - If req drops mid-transaction, the transaction still completes and ack still pulses.
- Reset (`reset` high at a clock edge):
  - FSM goes to IDLE, the counter clears and the RR pointer is set to favour D.
  - All outputs go to 0: `mm_read`, `mm_write`, `mm_addr`, `mm_wdata`, `i_ack`, `d_ack`, `i_rdata`, `d_rdata`, `busy`.
  - Reset in mid-access abandons the access. Strobes are low in the first post-reset cycle and no ack is issued.

## Timing
- Request sampled in IDLE at cycle 0:
  - `mm_read`/`mm_write` are high in cycles 1..MEM_LAT.
  - `mm_rdata` is sampled at the end of cycle MEM_LAT.
  - Ack is high in cycle MEM_LAT+1.
- Request-to-ack latency is MEM_LAT+1 cycles; with the default MEM_LAT = 2, ack arrives in cycle 3.
- Back-to-back requests are granted in the IDLE cycle after ACK. Peak throughput is one access every MEM_LAT+2 cycles.
- Strobes are never high in IDLE or ACK. `mm_read` and `mm_write` are mutually exclusive.
- `i_ack` and `d_ack` are registered outputs, mutually exclusive, and each is exactly one cycle wide.

## Structure
- Package `mm_arb_pkg` holds:
  - the state enum `{IDLE, BUSY, ACK}`;
  - the owner encoding `{OWN_I, OWN_D}`;
  - the default DATA_W, ADDR_W and MEM_LAT constants.
- One sub-module, `rr_arb2`: a two-requester round-robin arbiter.
  - Inputs: `clk`, `reset`, `req[1:0]`, `advance`.
  - Output: one-hot `gnt[1:0]`.
  - Holds the last-grant pointer and updates it on `advance` (the grant taken in IDLE).

## Test plan
- Single fetch: `i_req` = 1, `i_addr` = 8'h10, memory returns 8'hA5 → `mm_read` high for cycles 1–2 with `mm_addr` = 8'h10; `i_ack` in cycle 3; `i_rdata` = 8'hA5; `d_ack` stays 0.
- Write-back: `d_req` = 1, `d_we` = 1, `d_addr` = 8'h24, `d_wdata` = 8'h3C → `mm_write` high for 2 cycles with `mm_wdata` = 8'h3C; `d_ack` in cycle 3; `d_rdata` unchanged.
- Contention: `i_req` and `d_req` rise together after reset → D is served first (ack in cycle 3), then I is granted in cycle 4 with ack in cycle 7. Repeating the pattern alternates the grant order.
- Stable registration: after the grant, change `d_addr` from 8'h08 to 8'hFF mid-access and drop `d_req` → `mm_addr` stays 8'h08 and `d_ack` still pulses.
- Reset mid-op: assert `reset` in cycle 2 of a read → all outputs are 0 in the next cycle and no ack appears. A new `i_req` is then served with normal latency.
- MEM_LAT = 1 build: single read → strobe for 1 cycle, ack in cycle 2.

Source files
------------

// File: rtl/mm_arbiter_pkg.sv
// Shared types and default sizing for the main-memory arbiter slice.
package mm_arb_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 8;
  localparam int MEM_LAT_DEF = 2;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  // Owner value doubles as the bit index into the two-bit request/grant vectors.
  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/mm_arbiter_if.sv
// Client-side request/ack signals and the main-memory bus.
interface mm_arbiter_if
  import mm_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mm_read;
  logic              mm_write;
  logic [ADDR_W-1:0] mm_addr;
  logic [DATA_W-1:0] mm_wdata;
  logic [DATA_W-1:0] mm_rdata;

  logic              busy;

  // master: the clients plus memory model; slave: the arbiter itself.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mm_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mm_read, mm_write, mm_addr, mm_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mm_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mm_read, mm_write, mm_addr, mm_wdata, busy
  );

endinterface

// File: rtl/mm_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers who was granted last.
module rr_arb2
  import mm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  owner_t last_q;

  // Reset pretends I was served last so that D wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= OWN_I;
    end else if (advance && (|req)) begin
      last_q <= gnt[OWN_D] ? OWN_D : OWN_I;
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_q == OWN_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mm_arbiter.sv
// Main-memory arbiter/sequencer: grants fetch or data-cache, runs a fixed-length
// memory access, and returns a one-cycle ack with the captured read data.
module mm_arbiter
  import mm_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
)(
  input  logic         clk,
  input  logic         reset,
  mm_arbiter_if.slave  bus
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              i_ack_q, d_ack_q;
  logic [1:0]        gnt;
  logic              grant_take;
  logic              last_beat;

  assign last_beat = (cnt_q == LAST_CNT);

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.d_req, bus.i_req}),
    .advance (grant_take),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant_take = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY:    if (last_beat) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The winner's request is frozen at grant so later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_I;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_take) begin
            cnt_q <= '0;
            if (gnt[OWN_D]) begin
              owner_q <= OWN_D;
              addr_q  <= bus.d_addr;
              wdata_q <= bus.d_wdata;
              we_q    <= bus.d_we;
            end else begin
              owner_q <= OWN_I;
              addr_q  <= bus.i_addr;
              wdata_q <= '0;
              we_q    <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (last_beat) begin
            if (!we_q) rdata_q <= bus.mm_rdata;
            i_ack_q <= (owner_q == OWN_I);
            d_ack_q <= (owner_q == OWN_D);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mm_read  = (state_q == BUSY) && !we_q;
  assign bus.mm_write = (state_q == BUSY) && we_q && (owner_q == OWN_D);
  assign bus.mm_addr  = addr_q;
  assign bus.mm_wdata = wdata_q;
  assign bus.i_rdata  = rdata_q;
  assign bus.d_rdata  = rdata_q;
  assign bus.i_ack    = i_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mm_arbiter.sv
// Self-checking bench for mm_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of arbitration, timing and memory.
module tb_mm_arbiter;
  import mm_arb_pkg::*;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic mem_clear;
  always #5 clk = ~clk;

  mm_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mm_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  mm_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mm_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Main memory behind the LAT=2 instance; background pattern is addr ^ 8'hB5.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'hB5;
    end else if (bus.mm_write) begin
      mem[bus.mm_addr] <= bus.mm_wdata;
    end
  end
  assign bus.mm_rdata  = mem[bus.mm_addr];
  assign bus1.mm_rdata = bus1.mm_addr ^ 8'hB5;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] ref_mem [256];
  bit         last_d;
  logic [7:0] resp;
  bit         pi, pd, pd_we;
  logic [7:0] pi_addr, pd_addr, pd_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    bus.i_req   = pi;
    bus.i_addr  = pi_addr;
    bus.d_req   = pd;
    bus.d_we    = pd_we;
    bus.d_addr  = pd_addr;
    bus.d_wdata = pd_wdata;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},   32'(bus.busy),     32'd0);
    checkOutput({tag, "_read"},   32'(bus.mm_read),  32'd0);
    checkOutput({tag, "_write"},  32'(bus.mm_write), 32'd0);
    checkOutput({tag, "_iack"},   32'(bus.i_ack),    32'd0);
    checkOutput({tag, "_dack"},   32'(bus.d_ack),    32'd0);
    checkOutput({tag, "_irdata"}, 32'(bus.i_rdata),  32'(resp));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},   32'(bus.busy),     32'd0);
    checkOutput({tag, "_read"},   32'(bus.mm_read),  32'd0);
    checkOutput({tag, "_write"},  32'(bus.mm_write), 32'd0);
    checkOutput({tag, "_addr"},   32'(bus.mm_addr),  32'd0);
    checkOutput({tag, "_wdata"},  32'(bus.mm_wdata), 32'd0);
    checkOutput({tag, "_iack"},   32'(bus.i_ack),    32'd0);
    checkOutput({tag, "_dack"},   32'(bus.d_ack),    32'd0);
    checkOutput({tag, "_irdata"}, 32'(bus.i_rdata),  32'd0);
    checkOutput({tag, "_drdata"}, 32'(bus.d_rdata),  32'd0);
  endtask

  task automatic resetDut(input string tag);
    reset = 1'b1;
    pi = 1'b0;
    pd = 1'b0;
    applyStimulus();
    tick();
    last_d = 1'b0;
    resp   = '0;
    checkAllZero(tag);
    reset = 1'b0;
  endtask

  // One whole access from the current IDLE cycle through the following IDLE cycle.
  task automatic serve(input bit perturb);
    bit         w_d, we;
    logic [7:0] a, wd;
    checkIdle("pre");
    w_d = (pi && pd) ? !last_d : pd;
    a   = w_d ? pd_addr : pi_addr;
    we  = w_d ? pd_we : 1'b0;
    wd  = pd_wdata;
    last_d = w_d;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checkOutput("strobe_busy", 32'(bus.busy),     32'd1);
      checkOutput("mm_read",     32'(bus.mm_read),  32'(!we));
      checkOutput("mm_write",    32'(bus.mm_write), 32'(we));
      checkOutput("mm_addr",     32'(bus.mm_addr),  32'(a));
      if (we) checkOutput("mm_wdata", 32'(bus.mm_wdata), 32'(wd));
      if (perturb && k == 1) begin
        if (w_d) begin
          pd = 1'b0; pd_addr = 8'hFF; pd_wdata = ~pd_wdata; pd_we = ~pd_we;
        end else begin
          pi = 1'b0; pi_addr = 8'hFF;
        end
        applyStimulus();
      end
    end
    tick();
    if (we) ref_mem[a] = wd;
    else    resp = ref_mem[a];
    checkOutput("ack_i",     32'(bus.i_ack),    32'(!w_d));
    checkOutput("ack_d",     32'(bus.d_ack),    32'(w_d));
    checkOutput("ack_busy",  32'(bus.busy),     32'd1);
    checkOutput("ack_read",  32'(bus.mm_read),  32'd0);
    checkOutput("ack_write", 32'(bus.mm_write), 32'd0);
    checkOutput("i_rdata",   32'(bus.i_rdata),  32'(resp));
    checkOutput("d_rdata",   32'(bus.d_rdata),  32'(resp));
    if (w_d) pd = 1'b0;
    else     pi = 1'b0;
    applyStimulus();
    tick();
  endtask

  initial begin
    pi = 0; pd = 0; pd_we = 0; pi_addr = '0; pd_addr = '0; pd_wdata = '0;
    resp = '0; last_d = 0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0;
    bus1.d_we = 1'b0; bus1.d_addr = '0; bus1.d_wdata = '0;
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'hB5;
    mem_clear = 1'b1;
    resetDut("reset");
    mem_clear = 1'b0;

    // Single fetch from 8'h10 (memory holds 8'hA5 there).
    pi = 1; pi_addr = 8'h10; applyStimulus();
    serve(0);

    // Write-back, then read it back through the data port.
    pd = 1; pd_we = 1; pd_addr = 8'h24; pd_wdata = 8'h3C; applyStimulus();
    serve(0);
    pd = 1; pd_we = 0; pd_addr = 8'h24; applyStimulus();
    serve(0);

    // Contention straight after reset: D first, then I, then the pattern again.
    resetDut("reset2");
    pi = 1; pi_addr = 8'h31; pd = 1; pd_we = 0; pd_addr = 8'h24; applyStimulus();
    serve(0);
    serve(0);
    pi = 1; pi_addr = 8'h32; pd = 1; pd_we = 1; pd_addr = 8'h50; pd_wdata = 8'h77; applyStimulus();
    serve(0);
    serve(0);

    // Inputs change and req drops after the grant.
    pd = 1; pd_we = 0; pd_addr = 8'h08; applyStimulus();
    serve(1);

    // Reset in the middle of a read.
    pi = 1; pi_addr = 8'h40; applyStimulus();
    checkIdle("mid_pre");
    tick();
    checkOutput("mid_read", 32'(bus.mm_read), 32'd1);
    tick();
    reset = 1'b1; pi = 0; applyStimulus();
    tick();
    last_d = 1'b0;
    resp   = '0;
    checkAllZero("mid_rst");
    reset = 1'b0;
    tick();
    checkAllZero("mid_post");
    pi = 1; pi_addr = 8'h41; applyStimulus();
    serve(0);

    // MEM_LAT = 1 instance: strobe for one cycle, ack in cycle 2.
    bus1.i_req = 1'b1; bus1.i_addr = 8'h33;
    tick();
    checkOutput("lat1_read", 32'(bus1.mm_read), 32'd1);
    checkOutput("lat1_addr", 32'(bus1.mm_addr), 32'h33);
    tick();
    checkOutput("lat1_read_off", 32'(bus1.mm_read), 32'd0);
    checkOutput("lat1_ack",      32'(bus1.i_ack),   32'd1);
    checkOutput("lat1_rdata",    32'(bus1.i_rdata), 32'(8'h33 ^ 8'hB5));
    bus1.i_req = 1'b0;
    tick();
    checkOutput("lat1_ack_off", 32'(bus1.i_ack), 32'd0);
    checkOutput("lat1_idle",    32'(bus1.busy),  32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      if (!pi && ($urandom_range(0, 1) == 1)) begin
        pi = 1; pi_addr = 8'($urandom);
      end
      if (!pd && ($urandom_range(0, 1) == 1)) begin
        pd = 1; pd_we = 1'($urandom); pd_addr = 8'($urandom); pd_wdata = 8'($urandom);
      end
      applyStimulus();
      if (pi || pd) serve($urandom_range(0, 3) == 0);
      else begin
        checkIdle("gap");
        tick();
      end
    end
    repeat (2) if (pi || pd) serve(0);
    checkIdle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
